// File: rtl/board_pkg.sv
// Shared board geometry, opcodes, cell payload and the VRAM address formula.
// Used by the VRAM writer and the VGA renderer read path.
package board_pkg;

    localparam int unsigned BOARD_W     = 14;
    localparam int unsigned BOARD_H     = 14;
    localparam int unsigned CELL_BITS   = 6;
    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned MAX_CELLS   = 5;
    localparam int unsigned BOARD_CELLS = BOARD_W * BOARD_H;
    localparam int unsigned COORD_W     = 4;
    localparam int unsigned POS_W       = 5;
    localparam int unsigned OFF_W       = 3;
    localparam int unsigned SHAPE_W     = 2 * OFF_W * MAX_CELLS;
    localparam int unsigned COUNT_W     = 3;
    localparam int unsigned CNT_W       = ADDR_W;

    localparam logic [CELL_BITS-1:0] COLOR_EMPTY = '0;
    localparam logic [CELL_BITS-1:0] CLEAR_VAL   = COLOR_EMPTY;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'd0,
        OP_SET   = 2'd1,
        OP_STAMP = 2'd2,
        OP_NOP   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLR   = 2'd1,
        ST_STAMP = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    // Latched command payload
    typedef struct packed {
        logic [COORD_W-1:0]   x;
        logic [COORD_W-1:0]   y;
        logic [CELL_BITS-1:0] data;
        logic [SHAPE_W-1:0]   shape;
        logic [COUNT_W-1:0]   n;
    } cmd_t;

    // Offset pair {dy,dx} of cell k; indices past the last cell read as zero
    function automatic logic [2*OFF_W-1:0] shape_cell(input logic [SHAPE_W-1:0] shape,
                                                      input logic [2:0]         k);
        logic [2*OFF_W-1:0] r;
        case (k)
            3'd0:    r = shape[5:0];
            3'd1:    r = shape[11:6];
            3'd2:    r = shape[17:12];
            3'd3:    r = shape[23:18];
            3'd4:    r = shape[29:24];
            default: r = '0;
        endcase
        return r;
    endfunction

    // Cell count after clamping: 0 stays 0, anything above MAX_CELLS becomes MAX_CELLS
    function automatic logic [COUNT_W-1:0] clamp_count(input logic [COUNT_W-1:0] c);
        return (c > COUNT_W'(MAX_CELLS)) ? COUNT_W'(MAX_CELLS) : c;
    endfunction

    // y*14 + x without a multiplier
    function automatic logic [ADDR_W-1:0] board_addr(input logic [POS_W-1:0] x,
                                                     input logic [POS_W-1:0] y);
        logic [ADDR_W-1:0] y8;
        y8 = ADDR_W'(y);
        return ADDR_W'((y8 << 4) - (y8 << 1) + ADDR_W'(x));
    endfunction

endpackage

// File: rtl/board_addr_calc.sv
// Combinational cell address and bounds check from 5-bit board coordinates.
module board_addr_calc
    import board_pkg::*;
(
    input  logic [POS_W-1:0]  x_i,
    input  logic [POS_W-1:0]  y_i,
    output logic [ADDR_W-1:0] addr_c_o,
    output logic              in_bounds_c_o
);

    // Address formula shared with the renderer; bounds checked on the full sums
    always_comb begin
        addr_c_o      = board_addr(x_i, y_i);
        in_bounds_c_o = (x_i < POS_W'(BOARD_W)) && (y_i < POS_W'(BOARD_H));
    end

endmodule

// File: rtl/board_vram_writer.sv
// Write-side master for the 14x14 board VRAM: CLEAR, SET_CELL and STAMP_PIECE
// commands, one RAM write per cycle, done/skipped on completion.
// Optional: BOARD_CLEAR_ON_RESET_EN sweeps the board to CLEAR_VAL after reset.
module board_vram_writer
    import board_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [COORD_W-1:0]   cmd_x,
    input  logic [COORD_W-1:0]   cmd_y,
    input  logic [CELL_BITS-1:0] cmd_data,
    input  logic [SHAPE_W-1:0]   cmd_shape,
    input  logic [COUNT_W-1:0]   cmd_count,
    output logic [ADDR_W-1:0]    wraddress,
    output logic [CELL_BITS-1:0] data,
    output logic                 wren,
    output logic                 busy,
    output logic                 done,
    output logic                 skipped
);

`ifdef BOARD_CLEAR_ON_RESET_EN
    localparam state_e RST_STATE = ST_CLR;
    localparam logic   RST_ARM   = 1'b1;
`else
    localparam state_e RST_STATE = ST_IDLE;
    localparam logic   RST_ARM   = 1'b0;
`endif
    localparam logic RST_READY = (RST_STATE == ST_IDLE);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    cmd_t                 cmd_q, cmd_d;
    logic                 skip_q, skip_d;
    logic                 arm_q, arm_d;
    logic [ADDR_W-1:0]    wraddress_q, wraddress_d;
    logic [CELL_BITS-1:0] data_q, data_d;
    logic                 wren_q, wren_d;
    logic                 done_q, done_d;
    logic                 skipped_q, skipped_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;

    cmd_t                 src;
    logic [2:0]           k_sel;
    logic [2*OFF_W-1:0]   off;
    logic [POS_W-1:0]     cell_x, cell_y;
    logic [ADDR_W-1:0]    cell_addr;
    logic                 cell_in_bounds;

    // Cell source: live command fields while idle, latched fields otherwise
    always_comb begin
        src   = cmd_q;
        k_sel = 3'(cnt_q[2:0] + 3'd1);
        if (state_q == ST_IDLE) begin
            src.x     = cmd_x;
            src.y     = cmd_y;
            src.data  = cmd_data;
            src.shape = (cmd_op == OP_SET) ? '0 : cmd_shape;
            src.n     = (cmd_op == OP_SET) ? COUNT_W'(1) : clamp_count(cmd_count);
            k_sel     = 3'd0;
        end
        off    = shape_cell(src.shape, k_sel);
        cell_x = POS_W'(src.x) + POS_W'(off[OFF_W-1:0]);
        cell_y = POS_W'(src.y) + POS_W'(off[2*OFF_W-1:OFF_W]);
    end

    board_addr_calc u_addr (
        .x_i           (cell_x),
        .y_i           (cell_y),
        .addr_c_o      (cell_addr),
        .in_bounds_c_o (cell_in_bounds)
    );

    // Next state plus the registered write/status outputs for the next cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        skip_d      = skip_q;
        arm_d       = arm_q;
        wraddress_d = wraddress_q;
        data_d      = data_q;
        wren_d      = 1'b0;
        done_d      = 1'b0;
        skipped_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d  = src;
                    cnt_d  = '0;
                    skip_d = 1'b0;
                    case (op_e'(cmd_op))
                        OP_CLEAR: begin
                            state_d     = ST_CLR;
                            wren_d      = 1'b1;
                            wraddress_d = '0;
                            data_d      = CLEAR_VAL;
                        end
                        OP_SET, OP_STAMP: begin
                            if (src.n == '0) begin
                                state_d = ST_FIN;
                                done_d  = 1'b1;
                            end else begin
                                state_d = ST_STAMP;
                                if (cell_in_bounds) begin
                                    wren_d      = 1'b1;
                                    wraddress_d = cell_addr;
                                    data_d      = src.data;
                                end else begin
                                    skip_d = 1'b1;
                                end
                            end
                        end
                        default: begin
                            state_d = ST_FIN;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end

            ST_CLR: begin
                if (arm_q) begin
                    arm_d       = 1'b0;
                    wren_d      = 1'b1;
                    wraddress_d = ADDR_W'(cnt_q);
                    data_d      = CLEAR_VAL;
                end else if (cnt_q == CNT_W'(BOARD_CELLS - 1)) begin
                    state_d = ST_FIN;
                    done_d  = 1'b1;
                end else begin
                    cnt_d       = CNT_W'(cnt_q + 1'b1);
                    wren_d      = 1'b1;
                    wraddress_d = ADDR_W'(cnt_q + 1'b1);
                    data_d      = CLEAR_VAL;
                end
            end

            ST_STAMP: begin
                if (cnt_q == CNT_W'(cmd_q.n - 1'b1)) begin
                    state_d   = ST_FIN;
                    done_d    = 1'b1;
                    skipped_d = skip_q;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                    if (cell_in_bounds) begin
                        wren_d      = 1'b1;
                        wraddress_d = cell_addr;
                        data_d      = cmd_q.data;
                    end else begin
                        skip_d = 1'b1;
                    end
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any command in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            skip_q      <= 1'b0;
            arm_q       <= RST_ARM;
            wraddress_q <= '0;
            data_q      <= '0;
            wren_q      <= 1'b0;
            done_q      <= 1'b0;
            skipped_q   <= 1'b0;
            ready_q     <= RST_READY;
            busy_q      <= ~RST_READY;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            skip_q      <= skip_d;
            arm_q       <= arm_d;
            wraddress_q <= wraddress_d;
            data_q      <= data_d;
            wren_q      <= wren_d;
            done_q      <= done_d;
            skipped_q   <= skipped_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready = ready_q;
    assign wraddress = wraddress_q;
    assign data      = data_q;
    assign wren      = wren_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign skipped   = skipped_q;

endmodule

// File: tb/tb_board_vram_writer.sv
// Directed bench for board_vram_writer; honours BOARD_CLEAR_ON_RESET_EN.
module tb_board_vram_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_x, cmd_y;
    logic [5:0]  cmd_data;
    logic [29:0] cmd_shape;
    logic [2:0]  cmd_count;
    logic [7:0]  wraddress;
    logic [5:0]  data;
    logic        wren, busy, done, skipped;

    int n_checks = 0;
    int n_pass   = 0;

    board_vram_writer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_data  (cmd_data),
        .cmd_shape (cmd_shape),
        .cmd_count (cmd_count),
        .wraddress (wraddress),
        .data      (data),
        .wren      (wren),
        .busy      (busy),
        .done      (done),
        .skipped   (skipped)
    );

    always #5 clk = ~clk;

    // Offsets packed as {dy,dx} per cell, cell 0 in the low bits
    function automatic logic [29:0] mk_shape(input int dx0, input int dy0, input int dx1, input int dy1,
                                             input int dx2, input int dy2, input int dx3, input int dy3,
                                             input int dx4, input int dy4);
        logic [29:0] s;
        s = {3'(dy4), 3'(dx4), 3'(dy3), 3'(dx3), 3'(dy2), 3'(dx2), 3'(dy1), 3'(dx1), 3'(dy0), 3'(dx0)};
        return s;
    endfunction

    // Presents one command at a negedge, returns at the negedge of cycle T+1
    task automatic issue(input logic [1:0] op, input int x, input int y, input int d,
                         input logic [29:0] shape, input int cnt);
        int g;
        g = 0;
        while (!cmd_ready && g < 400) begin
            @(negedge clk);
            g++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL issue_ready_timeout: cmd_ready=%b want 1", cmd_ready);
        else n_pass++;
        cmd_op    = op;
        cmd_x     = 4'(x);
        cmd_y     = 4'(y);
        cmd_data  = 6'(d);
        cmd_shape = shape;
        cmd_count = 3'(cnt);
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Called at the negedge showing the first sweep write
    task automatic test_clear_sweep(input string tag);
        int bad_w, bad_a, bad_d, bad_r;
        bad_w = 0; bad_a = 0; bad_d = 0; bad_r = 0;
        for (int i = 0; i < 196; i++) begin
            if (wren !== 1'b1) bad_w++;
            if (wraddress !== 8'(i)) bad_a++;
            if (data !== 6'h00) bad_d++;
            if (cmd_ready !== 1'b0) bad_r++;
            @(negedge clk);
        end
        n_checks++;
        if (bad_w != 0) $display("FAIL %s_wren: %0d sweep cycles without wren, want 0", tag, bad_w);
        else n_pass++;
        n_checks++;
        if (bad_a != 0) $display("FAIL %s_addr: %0d sweep addresses out of order, want 0", tag, bad_a);
        else n_pass++;
        n_checks++;
        if (bad_d != 0) $display("FAIL %s_data: %0d sweep words nonzero, want 0", tag, bad_d);
        else n_pass++;
        n_checks++;
        if (bad_r != 0) $display("FAIL %s_ready: cmd_ready high on %0d sweep cycles, want 0", tag, bad_r);
        else n_pass++;
        n_checks++;
        if ({done, skipped, wren} !== 3'b100)
            $display("FAIL %s_done: done/skipped/wren=%b%b%b want 100", tag, done, skipped, wren);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, busy, done} !== 3'b100)
            $display("FAIL %s_idle: ready/busy/done=%b%b%b want 100", tag, cmd_ready, busy, done);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'd0; cmd_x = '0; cmd_y = '0; cmd_data = '0; cmd_shape = '0; cmd_count = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({wraddress, data, wren, done, skipped} !== 17'd0)
            $display("FAIL reset_outputs: addr=%0d data=%h wren=%b done=%b skipped=%b want all 0",
                     wraddress, data, wren, done, skipped);
        else n_pass++;
`ifdef BOARD_CLEAR_ON_RESET_EN
        n_checks++;
        if ({cmd_ready, busy} !== 2'b01) $display("FAIL reset_ready: ready/busy=%b%b want 01", cmd_ready, busy);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        test_clear_sweep("reset_sweep");
`else
        n_checks++;
        if ({cmd_ready, busy} !== 2'b10) $display("FAIL reset_ready: ready/busy=%b%b want 10", cmd_ready, busy);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
`endif
    endtask

    task automatic test_clear();
        issue(2'd0, 5, 5, 6'h3F, '1, 5);
        test_clear_sweep("clear");
    endtask

    task automatic test_set();
        issue(2'd1, 13, 13, 6'h2A, mk_shape(1, 1, 1, 1, 1, 1, 1, 1, 1, 1), 4);
        n_checks++;
        if ({wren, wraddress, data, done} !== {1'b1, 8'd195, 6'h2A, 1'b0})
            $display("FAIL set_write: wren=%b addr=%0d data=%h done=%b want 1/195/2a/0", wren, wraddress, data, done);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({done, skipped, wren, wraddress, data} !== {3'b100, 8'd195, 6'h2A})
            $display("FAIL set_done: done=%b skipped=%b wren=%b addr=%0d data=%h want 1/0/0/195/2a",
                     done, skipped, wren, wraddress, data);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_stamp();
        int ea[5];
        ea = '{44, 45, 46, 60, 74};
        issue(2'd2, 2, 3, 5, mk_shape(0, 0, 1, 0, 2, 0, 2, 1, 2, 2), 5);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({wren, wraddress, data, done} !== {1'b1, 8'(ea[k]), 6'd5, 1'b0})
                $display("FAIL stamp_cell%0d: wren=%b addr=%0d data=%0d done=%b want 1/%0d/5/0",
                         k, wren, wraddress, data, done, ea[k]);
            else n_pass++;
            @(negedge clk);
        end
        n_checks++;
        if ({done, skipped, wren} !== 3'b100)
            $display("FAIL stamp_done: done/skipped/wren=%b%b%b want 100", done, skipped, wren);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_stamp_oob();
        int ea[5];
        logic ew[5];
        ea = '{180, 181, 181, 194, 194};
        ew = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        issue(2'd2, 12, 12, 9, mk_shape(0, 0, 1, 0, 2, 0, 0, 1, 0, 2), 5);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({wren, wraddress, data, done} !== {ew[k], 8'(ea[k]), 6'd9, 1'b0})
                $display("FAIL oob_cell%0d: wren=%b addr=%0d data=%0d done=%b want %b/%0d/9/0",
                         k, wren, wraddress, data, done, ew[k], ea[k]);
            else n_pass++;
            @(negedge clk);
        end
        n_checks++;
        if ({done, skipped, wren} !== 3'b110)
            $display("FAIL oob_done: done/skipped/wren=%b%b%b want 110", done, skipped, wren);
        else n_pass++;
        @(negedge clk);
    endtask

    // Count 0 and reserved opcode: no writes, done on the first cycle; count 7 clamps to 5
    task automatic test_edge_counts();
        int w;
        issue(2'd2, 1, 1, 3, '0, 0);
        n_checks++;
        if ({done, skipped, wren} !== 3'b100)
            $display("FAIL count0_done: done/skipped/wren=%b%b%b want 100", done, skipped, wren);
        else n_pass++;
        @(negedge clk);
        issue(2'd3, 1, 1, 3, '0, 5);
        n_checks++;
        if ({done, skipped, wren} !== 3'b100)
            $display("FAIL op3_done: done/skipped/wren=%b%b%b want 100", done, skipped, wren);
        else n_pass++;
        @(negedge clk);
        issue(2'd2, 0, 0, 1, mk_shape(0, 0, 1, 0, 2, 0, 3, 0, 4, 0), 7);
        w = 0;
        while (!done && w < 20) begin
            if (wren) w++;
            @(negedge clk);
        end
        n_checks++;
        if (w != 5 || wraddress !== 8'd4) $display("FAIL count7_clamp: writes=%0d last=%0d want 5/4", w, wraddress);
        else n_pass++;
        @(negedge clk);
    endtask

    // cmd_valid held through a CLEAR: second command taken once, right after done
    task automatic test_back_to_back();
        int ready_at, done_at, accepts, seen_set;
        logic drop;
        ready_at = -1; done_at = -1; accepts = 0; seen_set = 0; drop = 1'b0;
        issue(2'd0, 0, 0, 0, '0, 1);
        cmd_op = 2'd1; cmd_x = 4'd0; cmd_y = 4'd1; cmd_data = 6'd7; cmd_count = 3'd1;
        cmd_valid = 1'b1;
        for (int c = 1; c < 206; c++) begin
            if (drop) begin
                cmd_valid = 1'b0;
                drop = 1'b0;
                if (wren && wraddress == 8'd14 && data == 6'd7) seen_set++;
            end
            if (done && done_at < 0) done_at = c;
            if (cmd_ready && ready_at < 0) ready_at = c;
            if (cmd_ready && cmd_valid) begin
                accepts++;
                drop = 1'b1;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (done_at != 197) $display("FAIL b2b_done_cycle: done at T+%0d want T+197", done_at);
        else n_pass++;
        n_checks++;
        if (ready_at != 198) $display("FAIL b2b_ready_cycle: ready at T+%0d want T+198", ready_at);
        else n_pass++;
        n_checks++;
        if (accepts != 1 || seen_set != 1)
            $display("FAIL b2b_accepts: accepts=%0d set_writes=%0d want 1/1", accepts, seen_set);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        issue(2'd0, 0, 0, 0, '0, 1);
        repeat (50) @(negedge clk);
        rst = 1'b1;
        #1;
`ifdef BOARD_CLEAR_ON_RESET_EN
        n_checks++;
        if ({wren, cmd_ready, done} !== 3'b000)
            $display("FAIL reset_mid: wren/ready/done=%b%b%b want 000", wren, cmd_ready, done);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_clear_sweep("reset_mid_sweep");
`else
        n_checks++;
        if ({wren, cmd_ready, done, busy} !== 4'b0100)
            $display("FAIL reset_mid: wren/ready/done/busy=%b%b%b%b want 0100", wren, cmd_ready, done, busy);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({wren, cmd_ready} !== 2'b01) $display("FAIL reset_mid_after: wren/ready=%b%b want 01", wren, cmd_ready);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_clear();
        test_set();
        test_stamp();
        test_stamp_oob();
        test_edge_counts();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
